servo_pwm_driver: RTL and testbench



---
 rtl/servo_pwm_driver.sv | 145 ++++++++++++++
 tb/tb_servo_pwm_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: turns the sequencer's servo-select/duty command into
// NUM_SERVOS continuous PWM frames and returns a one-cycle end-of-frame strobe
// that the sequencer uses as its time base.
//
// Ports:
//   Clock                 system clock
//   Reset                 synchronous, active-high reset (overrides Enable)
//   Enable                run PWM frames; low returns to idle
//   ServoNum              servo addressed by the current command
//   ActiveServoDuty       commanded high time (cycles) for ServoNum
//   ServoPWM              registered PWM pins, bit i drives servo i
//   ActivePeriodFinished  registered one-cycle strobe per completed frame
//   DutyClamped           registered sticky flag: a sampled command was clamped
module servo_pwm_driver #(
    parameter int unsigned PERIOD_CYCLES = 2_000_000,
    parameter int unsigned NUM_SERVOS    = 4,
    parameter int unsigned MIN_DUTY      = 50_000,
    parameter int unsigned MAX_DUTY      = 250_000,
    parameter int unsigned DEFAULT_DUTY  = 150_000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [1:0]            ServoNum,
    input  logic [20:0]           ActiveServoDuty,
    output logic [NUM_SERVOS-1:0] ServoPWM,
    output logic                  ActivePeriodFinished,
    output logic                  DutyClamped
);

    localparam int unsigned W = 21;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            cnt_q, cnt_d;
    logic [W-1:0]            duty_q [NUM_SERVOS];
    logic [W-1:0]            duty_d [NUM_SERVOS];
    logic [NUM_SERVOS-1:0]   pwm_q, pwm_d;
    logic                    apf_q, apf_d;
    logic                    clamped_q, clamped_d;

    logic [W-1:0]            cmd_clamped;
    logic                    cmd_out_of_range;
    logic                    cmd_hit;
    logic                    frame_last;

    // Clamp the incoming command to the legal pulse-width window.
    always_comb begin
        cmd_clamped      = ActiveServoDuty;
        cmd_out_of_range = 1'b0;
        if (ActiveServoDuty < W'(MIN_DUTY)) begin
            cmd_clamped      = W'(MIN_DUTY);
            cmd_out_of_range = 1'b1;
        end else if (ActiveServoDuty > W'(MAX_DUTY)) begin
            cmd_clamped      = W'(MAX_DUTY);
            cmd_out_of_range = 1'b1;
        end
    end

    assign frame_last = (cnt_q == W'(PERIOD_CYCLES - 1));

    // Next-state, frame counter, command sampling and registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        pwm_d     = '0;
        apf_d     = 1'b0;
        clamped_d = clamped_q;
        cmd_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!Enable) begin
                    // Aborted frame: no strobe, pins low, duties kept.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = frame_last ? '0 : cnt_q + W'(1);
                    apf_d = frame_last;

                    // Commands are only taken at the frame boundary so a
                    // pulse in flight is never cut short or stretched.
                    if (cnt_q == '0) begin
                        for (int i = 0; i < int'(NUM_SERVOS); i++) begin
                            if (ServoNum == 2'(i)) begin
                                duty_d[i] = cmd_clamped;
                                cmd_hit   = 1'b1;
                            end
                        end
                        if (cmd_hit && cmd_out_of_range) begin
                            clamped_d = 1'b1;
                        end
                    end

                    // Compares against the stored duty, so a fresh command
                    // takes effect one cycle into its first frame.
                    for (int i = 0; i < int'(NUM_SERVOS); i++) begin
                        pwm_d[i] = (cnt_q < duty_q[i]);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < int'(NUM_SERVOS); i++) begin
                duty_q[i] <= W'(DEFAULT_DUTY);
            end
            pwm_q     <= '0;
            apf_q     <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            apf_q     <= apf_d;
            clamped_q <= clamped_d;
        end
    end

    assign ServoPWM             = pwm_q;
    assign ActivePeriodFinished = apf_q;
    assign DutyClamped          = clamped_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
module tb_servo_pwm_driver;

    localparam int P    = 1000;
    localparam int NS   = 4;
    localparam int MINV = 50;
    localparam int MAXV = 250;
    localparam int DEF  = 150;

    logic           Clock;
    logic           Reset;
    logic           Enable;
    logic [1:0]     ServoNum;
    logic [20:0]    ActiveServoDuty;
    logic [NS-1:0]  ServoPWM;
    logic           ActivePeriodFinished;
    logic           DutyClamped;

    servo_pwm_driver #(
        .PERIOD_CYCLES (P),
        .NUM_SERVOS    (NS),
        .MIN_DUTY      (MINV),
        .MAX_DUTY      (MAXV),
        .DEFAULT_DUTY  (DEF)
    ) dut (
        .Clock                (Clock),
        .Reset                (Reset),
        .Enable               (Enable),
        .ServoNum             (ServoNum),
        .ActiveServoDuty      (ActiveServoDuty),
        .ServoPWM             (ServoPWM),
        .ActivePeriodFinished (ActivePeriodFinished),
        .DutyClamped          (DutyClamped)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: time since the run started, modulo the frame length,
    // decides the frame phase; outputs follow from phase versus held duty.
    typedef struct packed {
        logic                 run;
        logic [31:0]          cyc;
        logic [31:0]          start;
        logic [NS-1:0][20:0]  duty;
        logic                 clamp;
        logic [NS-1:0]        pwm;
        logic                 apf;
        logic [31:0]          cnt;
    } model_t;

    model_t m_q = '0;

    function automatic model_t model_next(model_t m, logic rst, logic en,
                                          logic [1:0] sn, logic [20:0] d);
        model_t n;
        int ph;
        int v;
        n       = m;
        n.cyc   = m.cyc + 32'd1;
        n.pwm   = '0;
        n.apf   = 1'b0;
        if (rst) begin
            n.run   = 1'b0;
            n.clamp = 1'b0;
            for (int i = 0; i < NS; i++) n.duty[i] = 21'(DEF);
        end else if (!m.run) begin
            if (en) begin
                n.run   = 1'b1;
                n.start = n.cyc;
            end
        end else if (!en) begin
            n.run = 1'b0;
        end else begin
            ph = int'((m.cyc - m.start) % 32'(P));
            if (ph == 0) begin
                v = int'(d);
                if (v < MINV) begin
                    v = MINV;
                    n.clamp = 1'b1;
                end else if (v > MAXV) begin
                    v = MAXV;
                    n.clamp = 1'b1;
                end
                n.duty[sn] = 21'(v);
            end
            for (int i = 0; i < NS; i++) n.pwm[i] = (ph < int'(m.duty[i]));
            n.apf = (ph == P - 1);
        end
        n.cnt = n.run ? (n.cyc - n.start) % 32'(P) : 32'd0;
        return n;
    endfunction

    always @(posedge Clock) m_q <= model_next(m_q, Reset, Enable, ServoNum, ActiveServoDuty);

    int n_checks = 0;
    int n_err    = 0;
    int hi [NS];
    int exp_d [NS];

    typedef struct {
        logic [1:0] sn;
        int         cmd;
        int         exp_duty;
        logic       exp_clamp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge Clock);
        n_checks++;
        if (ServoPWM !== m_q.pwm || ActivePeriodFinished !== m_q.apf ||
            DutyClamped !== m_q.clamp) begin
            n_err++;
            $display("FAIL model t=%0t pwm=%b exp=%b apf=%b exp=%b clamp=%b exp=%b",
                     $time, ServoPWM, m_q.pwm, ActivePeriodFinished, m_q.apf,
                     DutyClamped, m_q.clamp);
        end
    endtask

    task automatic wait_phase(input int p);
        int k;
        k = 0;
        while (!(m_q.run && m_q.cnt == 32'(p))) begin
            tick();
            k++;
            if (k > 3 * P) begin
                n_checks++;
                n_err++;
                $display("FAIL wait_phase p=%0d got=timeout exp=reached", p);
                break;
            end
        end
    endtask

    // High-cycle count of each pin over one frame, starting at phase 1.
    task automatic measure();
        for (int i = 0; i < NS; i++) hi[i] = 0;
        repeat (P) begin
            for (int i = 0; i < NS; i++) hi[i] = hi[i] + (ServoPWM[i] ? 1 : 0);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int k;
        int seen;

        tbl[0] = '{2'd2, 200, 200, 1'b0};
        tbl[1] = '{2'd0,  50,  50, 1'b0};
        tbl[2] = '{2'd3, 250, 250, 1'b0};
        tbl[3] = '{2'd1,  10,  50, 1'b1};
        tbl[4] = '{2'd1, 400, 250, 1'b1};
        tbl[5] = '{2'd0,  49,  50, 1'b1};
        for (int i = 0; i < NS; i++) exp_d[i] = DEF;

        Reset           = 1'b1;
        Enable          = 1'b0;
        ServoNum        = 2'd0;
        ActiveServoDuty = 21'(DEF);
        repeat (3) tick();
        chk("rst_pwm", int'(ServoPWM), 0);
        chk("rst_apf", int'(ActivePeriodFinished), 0);
        chk("rst_clamp", int'(DutyClamped), 0);

        // Idle with Enable low: nothing moves.
        Reset = 1'b0;
        repeat (5) tick();
        chk("idle_pwm", int'(ServoPWM), 0);

        // First strobe latency and frame spacing.
        Enable = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (ActivePeriodFinished !== 1'b1 && k <= 2 * P);
        chk("first_strobe", k, P + 1);
        k = 0;
        do begin
            tick();
            k++;
        end while (ActivePeriodFinished !== 1'b1 && k <= 2 * P);
        chk("strobe_spacing", k, P);

        // Default duty on all pins.
        wait_phase(1);
        measure();
        for (int i = 0; i < NS; i++) chk($sformatf("default_hi%0d", i), hi[i], DEF);

        // Table of commands applied mid-frame and measured on the next frame.
        for (int v = 0; v < 6; v++) begin
            wait_phase(500);
            ServoNum        = tbl[v].sn;
            ActiveServoDuty = 21'(tbl[v].cmd);
            wait_phase(1);
            measure();
            exp_d[tbl[v].sn] = tbl[v].exp_duty;
            for (int i = 0; i < NS; i++)
                chk($sformatf("vec%0d_hi%0d", v, i), hi[i], exp_d[i]);
            chk($sformatf("vec%0d_clamp", v), int'(DutyClamped), int'(tbl[v].exp_clamp));
        end

        // Mid-frame command glitch reverted before the boundary is ignored.
        wait_phase(500);
        ActiveServoDuty = 21'(100);
        wait_phase(900);
        ActiveServoDuty = 21'(49);
        wait_phase(1);
        measure();
        chk("glitch_hi0", hi[0], exp_d[0]);

        // Enable dropped mid-frame: pins low next cycle, no strobe while idle.
        wait_phase(600);
        Enable = 1'b0;
        tick();
        chk("drop_pwm", int'(ServoPWM), 0);
        chk("drop_apf", int'(ActivePeriodFinished), 0);
        seen = 0;
        repeat (P + 200) begin
            tick();
            if (ActivePeriodFinished) seen++;
        end
        chk("idle_no_strobe", seen, 0);
        Enable = 1'b1;
        wait_phase(1);
        measure();
        for (int i = 0; i < NS; i++) chk($sformatf("reen_hi%0d", i), hi[i], exp_d[i]);

        // Enable falling on the last frame cycle: no strobe.
        wait_phase(P - 1);
        Enable = 1'b0;
        tick();
        chk("last_cycle_drop_apf", int'(ActivePeriodFinished), 0);
        Enable = 1'b1;

        // Reset while servo 1 is mid-pulse.
        wait_phase(100);
        chk("pre_rst_pwm1", int'(ServoPWM[1]), 1);
        Reset           = 1'b1;
        ServoNum        = 2'd0;
        ActiveServoDuty = 21'(DEF);
        tick();
        chk("midrst_pwm", int'(ServoPWM), 0);
        chk("midrst_apf", int'(ActivePeriodFinished), 0);
        chk("midrst_clamp", int'(DutyClamped), 0);
        Reset = 1'b0;
        wait_phase(1);
        measure();
        for (int i = 0; i < NS; i++) chk($sformatf("post_rst_hi%0d", i), hi[i], DEF);
        chk("post_rst_clamp", int'(DutyClamped), 0);

        // Randomised commands, enable toggles and resets against the model.
        for (int c = 0; c < 8000; c++) begin
            ServoNum        = 2'($urandom_range(0, 3));
            ActiveServoDuty = 21'($urandom_range(0, 400));
            if ($urandom_range(0, 1499) == 0) Enable = ~Enable;
            Reset = ($urandom_range(0, 4999) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
